// File: rtl/barrier_arrive_arbiter.sv
// rtl/barrier_arrive_arbiter.sv - round-robin arrive arbiter with pending-warp filter and wake broadcast
module barrier_arrive_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int PEND_DEPTH      = 8,
    parameter int WARPS_PER_BLOCK = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*16-1:0]         req_barrier_id,
    input  logic [NUM_PORTS*32-1:0]         req_thread_mask,
    input  logic [NUM_PORTS*10-1:0]         req_block_id,
    input  logic [NUM_PORTS*6-1:0]          req_warp_id,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [15:0]                     arrive_barrier_id,
    output logic [31:0]                     arrive_thread_mask,
    output logic [9:0]                      arrive_block_id,
    output logic [5:0]                      arrive_warp_id,
    output logic                            arrive_valid,
    input  logic                            arrive_ready,
    input  logic [15:0]                     release_barrier_id,
    input  logic [9:0]                      release_block_id,
    input  logic [WARPS_PER_BLOCK-1:0]      release_warp_mask,
    input  logic                            release_valid,
    output logic                            release_ready,
    output logic [9:0]                      wake_block_id,
    output logic [WARPS_PER_BLOCK-1:0]      wake_warp_mask,
    output logic                            wake_valid,
    output logic [$clog2(PEND_DEPTH+1)-1:0] pending_count,
    output logic [15:0]                     dup_count
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(PEND_DEPTH + 1);
    localparam logic [PW:0]   NP_NUM    = (PW + 1)'(NUM_PORTS);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
    localparam logic [CW-1:0] PEND_FULL = CW'(PEND_DEPTH);

    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic                       arrive_valid_q, arrive_valid_d;
    logic [15:0]                arrive_bar_q, arrive_bar_d;
    logic [31:0]                arrive_mask_q, arrive_mask_d;
    logic [9:0]                 arrive_blk_q, arrive_blk_d;
    logic [5:0]                 arrive_warp_q, arrive_warp_d;
    logic                       release_ready_q, release_ready_d;
    logic                       wake_valid_q, wake_valid_d;
    logic [9:0]                 wake_blk_q, wake_blk_d;
    logic [WARPS_PER_BLOCK-1:0] wake_mask_q, wake_mask_d;
    logic [CW-1:0]              pend_cnt_q, pend_cnt_d;
    logic [15:0]                dup_cnt_q, dup_cnt_d;
    logic [PEND_DEPTH-1:0]      ent_valid_q, ent_valid_d;
    logic [15:0]                ent_bar_q  [PEND_DEPTH];
    logic [15:0]                ent_bar_d  [PEND_DEPTH];
    logic [9:0]                 ent_blk_q  [PEND_DEPTH];
    logic [9:0]                 ent_blk_d  [PEND_DEPTH];
    logic [5:0]                 ent_warp_q [PEND_DEPTH];
    logic [5:0]                 ent_warp_d [PEND_DEPTH];

    logic                       can_grant;
    logic [2*NUM_PORTS-1:0]     req_dbl;
    logic [NUM_PORTS-1:0]       req_rot;
    logic [PW-1:0]              gnt_off;
    logic [PW:0]                gnt_sum;
    logic [PW-1:0]              gnt_idx;
    logic                       gnt_any;
    logic [15:0]                sel_bar;
    logic [31:0]                sel_mask;
    logic [9:0]                 sel_blk;
    logic [5:0]                 sel_warp;
    logic                       release_fire;
    logic [PEND_DEPTH-1:0]      ent_clr;
    logic [WARPS_PER_BLOCK-1:0] mask_sh;
    logic                       dup_hit;
    logic                       load;
    logic [PEND_DEPTH-1:0]      alloc_oh;
    logic                       alloc_found;

    // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit wins.
    always_comb begin
        can_grant = (!arrive_valid_q || arrive_ready) && (pend_cnt_q < PEND_FULL);
        req_dbl   = {req_valid, req_valid} >> rr_ptr_q;
        req_rot   = req_dbl[NUM_PORTS-1:0];
        gnt_any   = 1'b0;
        gnt_off   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_any = can_grant;
                gnt_off = PW'(i);
            end
        end
        gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= NP_NUM) begin
            gnt_sum = gnt_sum - NP_NUM;
        end
        gnt_idx   = gnt_sum[PW-1:0];
        req_ready = '0;
        sel_bar   = '0;
        sel_mask  = '0;
        sel_blk   = '0;
        sel_warp  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_any && (gnt_idx == PW'(p))) begin
                req_ready[p] = 1'b1;
                sel_bar      = req_barrier_id[16*p +: 16];
                sel_mask     = req_thread_mask[32*p +: 32];
                sel_blk      = req_block_id[10*p +: 10];
                sel_warp     = req_warp_id[6*p +: 6];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Entries cleared by this cycle's release no longer count as duplicates,
    // but their slots only become allocatable next cycle.
    always_comb begin
        release_fire = release_valid && release_ready_q;
        ent_clr      = '0;
        mask_sh      = '0;
        dup_hit      = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            mask_sh    = release_warp_mask >> ent_warp_q[i];
            ent_clr[i] = release_fire && ent_valid_q[i] &&
                         (ent_bar_q[i] == release_barrier_id) &&
                         (ent_blk_q[i] == release_block_id) && mask_sh[0];
            if (ent_valid_q[i] && !ent_clr[i] &&
                (ent_blk_q[i] == sel_blk) && (ent_warp_q[i] == sel_warp)) begin
                dup_hit = 1'b1;
            end
        end
        load        = gnt_any && !dup_hit;
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (!ent_valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
        ent_valid_d = ent_valid_q & ~ent_clr;
        ent_bar_d   = ent_bar_q;
        ent_blk_d   = ent_blk_q;
        ent_warp_d  = ent_warp_q;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (load && alloc_oh[i]) begin
                ent_valid_d[i] = 1'b1;
                ent_bar_d[i]   = sel_bar;
                ent_blk_d[i]   = sel_blk;
                ent_warp_d[i]  = sel_warp;
            end
        end
        pend_cnt_d = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(ent_valid_d[i]);
        end
    end

    always_comb begin
        arrive_valid_d = arrive_valid_q;
        arrive_bar_d   = arrive_bar_q;
        arrive_mask_d  = arrive_mask_q;
        arrive_blk_d   = arrive_blk_q;
        arrive_warp_d  = arrive_warp_q;
        if (load) begin
            arrive_valid_d = 1'b1;
            arrive_bar_d   = sel_bar;
            arrive_mask_d  = sel_mask;
            arrive_blk_d   = sel_blk;
            arrive_warp_d  = sel_warp;
        end else if (arrive_ready) begin
            arrive_valid_d = 1'b0;
        end
        dup_cnt_d = dup_cnt_q;
        if (gnt_any && dup_hit && (dup_cnt_q != 16'hFFFF)) begin
            dup_cnt_d = dup_cnt_q + 16'd1;
        end
        release_ready_d = 1'b1;
        wake_valid_d    = release_fire;
        wake_blk_d      = wake_blk_q;
        wake_mask_d     = wake_mask_q;
        if (release_fire) begin
            wake_blk_d  = release_block_id;
            wake_mask_d = release_warp_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q        <= '0;
            arrive_valid_q  <= 1'b0;
            arrive_bar_q    <= '0;
            arrive_mask_q   <= '0;
            arrive_blk_q    <= '0;
            arrive_warp_q   <= '0;
            release_ready_q <= 1'b0;
            wake_valid_q    <= 1'b0;
            wake_blk_q      <= '0;
            wake_mask_q     <= '0;
            pend_cnt_q      <= '0;
            dup_cnt_q       <= '0;
            ent_valid_q     <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                ent_bar_q[i]  <= '0;
                ent_blk_q[i]  <= '0;
                ent_warp_q[i] <= '0;
            end
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            arrive_valid_q  <= arrive_valid_d;
            arrive_bar_q    <= arrive_bar_d;
            arrive_mask_q   <= arrive_mask_d;
            arrive_blk_q    <= arrive_blk_d;
            arrive_warp_q   <= arrive_warp_d;
            release_ready_q <= release_ready_d;
            wake_valid_q    <= wake_valid_d;
            wake_blk_q      <= wake_blk_d;
            wake_mask_q     <= wake_mask_d;
            pend_cnt_q      <= pend_cnt_d;
            dup_cnt_q       <= dup_cnt_d;
            ent_valid_q     <= ent_valid_d;
            ent_bar_q       <= ent_bar_d;
            ent_blk_q       <= ent_blk_d;
            ent_warp_q      <= ent_warp_d;
        end
    end

    assign arrive_valid       = arrive_valid_q;
    assign arrive_barrier_id  = arrive_bar_q;
    assign arrive_thread_mask = arrive_mask_q;
    assign arrive_block_id    = arrive_blk_q;
    assign arrive_warp_id     = arrive_warp_q;
    assign release_ready      = release_ready_q;
    assign wake_valid         = wake_valid_q;
    assign wake_block_id      = wake_blk_q;
    assign wake_warp_mask     = wake_mask_q;
    assign pending_count      = pend_cnt_q;
    assign dup_count          = dup_cnt_q;

endmodule
